// File: rtl/hex_scan_mux.sv
// Digit scan multiplexer for a 4-digit common-anode display, with frame-synchronous value swap.
// Optional leading-zero suppression is enabled by defining LZS_EN.
module hex_scan_mux #(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] DATA,
    input  logic [3:0]  DP_MASK,
    input  logic        LOAD,
    input  logic        EN,
    output logic [3:0]  HEX,
    output logic [3:0]  AN,
    output logic        DP,
    output logic        FRAME,
    output logic        PENDING
);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [15:0]       pend_q, pend_d;
    logic [3:0]        pend_dp_q, pend_dp_d;
    logic              pending_q, pending_d;
    logic [15:0]       act_q, act_d;
    logic [3:0]        act_dp_q, act_dp_d;
    logic [3:0]        hex_q, hex_d;
    logic [3:0]        an_q, an_d;
    logic              dp_q, dp_d;
    logic              frame_q, frame_d;
    logic              boundary;
    logic              lit;
`ifdef LZS_EN
    logic              zero_above;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        pend_d    = pend_q;
        pend_dp_d = pend_dp_q;
        pending_d = pending_q;
        act_d     = act_q;
        act_dp_d  = act_dp_q;
        hex_d     = hex_q;
        an_d      = '1;
        dp_d      = 1'b1;
        frame_d   = 1'b0;
        lit       = 1'b1;
        boundary  = EN && (state_q == ST_BLANK) && (cnt_q == BLANK_LAST) && (idx_q == 2'd0);

        if (!EN) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            idx_d   = 2'd0;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_ON;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_ON: begin
                    if (cnt_q == DIGIT_LAST) begin
                        cnt_d   = '0;
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_BLANK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                end
            endcase
        end

        // Transfer first, then capture: a LOAD on the boundary edge stays pending.
        if (boundary) begin
            frame_d = 1'b1;
            if (pending_q) begin
                act_d     = pend_q;
                act_dp_d  = pend_dp_q;
                pending_d = 1'b0;
            end
        end
        if (LOAD) begin
            pend_d    = DATA;
            pend_dp_d = DP_MASK;
            pending_d = 1'b1;
        end

`ifdef LZS_EN
        zero_above = 1'b1;
        for (int unsigned j = 0; j < 4; j++) begin
            if ((j >= 32'(idx_d)) && ((act_d[4*j +: 4] != 4'd0) || act_dp_d[j]))
                zero_above = 1'b0;
        end
        lit = (idx_d == 2'd0) || !zero_above;
`endif

        // Outputs are derived from next-state so they register on the same edge as the FSM.
        if (state_d == ST_ON) begin
            hex_d = act_d[4*idx_d +: 4];
            if (lit) begin
                an_d[idx_d] = 1'b0;
                dp_d        = ~act_dp_d[idx_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_BLANK;
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            pend_q    <= '0;
            pend_dp_q <= '0;
            pending_q <= 1'b0;
            act_q     <= '0;
            act_dp_q  <= '0;
            hex_q     <= '0;
            an_q      <= '1;
            dp_q      <= 1'b1;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            pend_dp_q <= pend_dp_d;
            pending_q <= pending_d;
            act_q     <= act_d;
            act_dp_q  <= act_dp_d;
            hex_q     <= hex_d;
            an_q      <= an_d;
            dp_q      <= dp_d;
            frame_q   <= frame_d;
        end
    end

    assign HEX     = hex_q;
    assign AN      = an_q;
    assign DP      = dp_q;
    assign FRAME   = frame_q;
    assign PENDING = pending_q;

endmodule
